sliding_board_ctrl: RTL
=======================

Name: sliding_board_ctrl

Overview:
Parametrised ROWS x COLS sliding-puzzle board controller; successor to the fixed 4x4 blank-position FSM. Tracks the blank position and full tile arrangement, validates each directional request against board edges, and emits one-cycle move pulses with from/to indices for the renderer. Also provides a legal-move counter, a solved flag and a tile read port for display and win logic.

Parameters:
ROWS, 4, board rows (>=2)
COLS, 4, board columns (>=2)
CNT_W, 16, move counter width
IDX_W, $clog2(ROWS*COLS), cell index / tile value width (derived, not overridden)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
go  in  3  direction request: 000 none, 001 UP, 010 DOWN, 011 LEFT, 100 RIGHT; 101-111 treated as illegal requests
load  in  1  synchronous restore to solved board
rd_addr  in  IDX_W  cell index for tile read
rd_tile  out  IDX_W  tile value at rd_addr (combinational; 0 = blank)
blank_pos  out  IDX_W  current blank cell index
move_valid  out  1  one-cycle pulse, legal move committed
move_blocked  out  1  one-cycle pulse, request rejected
move_from  out  IDX_W  cell whose tile moved (new blank position)
move_to  out  IDX_W  cell the tile moved into (old blank position)
move_count  out  CNT_W  legal moves since reset/load, saturating
solved  out  1  board in solved arrangement

Behaviour:
- Cells indexed 0..N-1 row-major, N=ROWS*COLS; row=i/COLS, col=i%COLS. Tile values 1..N-1; blank stored as 0.
- Solved arrangement: cell i holds i+1 for i<N-1, cell N-1 blank.
- Reset (async, resetn=0): board solved, blank_pos=N-1, move_from=move_to=N-1, move_valid=move_blocked=0, move_count=0, FSM=IDLE. solved=1.
- Direction moves the blank: UP -> i+COLS (tile below slides up), DOWN -> i-COLS, LEFT -> i+1, RIGHT -> i-1.
- Legal iff target in same row (LEFT/RIGHT) or within 0..N-1 (UP/DOWN): UP needs row<ROWS-1, DOWN row>0, LEFT col<COLS-1, RIGHT col>0. No wrap across rows.
- FSM states: IDLE, HOLD.
  IDLE, go!=0 at edge: legal -> swap cells, blank_pos<=target, move_from<=target, move_to<=old blank, move_valid<=1, move_count+=1 (saturate at 2^CNT_W-1); illegal -> move_blocked<=1, board unchanged. Either case -> HOLD.
  HOLD: go==0 -> IDLE; otherwise stay. No moves or pulses in HOLD.
- Latency: pulse and updated board/blank_pos visible the cycle after the edge sampling go. Pulses last exactly one cycle; move_from/move_to hold until next legal move.
- solved: combinational from board registers, so it reflects the post-move state in the same cycle as move_valid.
- Direction change without passing through go=000 is ignored (stays HOLD).
- load=1 (sync, priority over go): board solved, blank_pos=N-1, move_from=move_to=N-1, count=0, pulses 0, FSM -> HOLD (a held key is not reinterpreted).
- resetn asserted mid-HOLD or mid-pulse: immediate return to reset values.
- Invariant: exactly one cell holds 0 and it equals blank_pos.

Test Plan:
- Reset, 4x4: solved=1, blank_pos=15, rd_tile(0)=1, rd_tile(15)=0, move_count=0, no pulses.
- From reset go=DOWN 1 cycle then 000: move_valid one cycle, move_from=11, move_to=15, blank_pos=11, rd_tile(15)=12, solved=0, count=1; then go=UP -> move_from=15, move_to=11, solved=1, count=2.
- At blank 15: go=UP and go=LEFT each -> move_blocked one cycle, board/count unchanged; go=110 -> move_blocked.
- go=RIGHT held 20 cycles -> exactly one move_valid (blank 15->14); switch to LEFT without release -> nothing; release then LEFT -> blank 15.
- ROWS=3, COLS=5: RIGHT x4 from blank 14 -> blank 10, fifth RIGHT blocked (no wrap to 9); DOWN -> blank 5.
- CNT_W=3: 9 legal alternating moves -> count saturates at 7; load with go held -> count 0, solved 1, no move until go released and reasserted.

Source files
------------

// File: rtl/sliding_board_ctrl.sv
// rtl/sliding_board_ctrl.sv - ROWS x COLS sliding-puzzle board controller
// Tracks tile arrangement and blank cell, validates directional moves and pulses move events.
module sliding_board_ctrl #(
  parameter  int ROWS  = 4,
  parameter  int COLS  = 4,
  parameter  int CNT_W = 16,
  localparam int N     = ROWS * COLS,
  localparam int IDX_W = $clog2(ROWS * COLS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [2:0]       go,
  input  logic             load,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [IDX_W-1:0] rd_tile,
  output logic [IDX_W-1:0] blank_pos,
  output logic             move_valid,
  output logic             move_blocked,
  output logic [IDX_W-1:0] move_from,
  output logic [IDX_W-1:0] move_to,
  output logic [CNT_W-1:0] move_count,
  output logic             solved
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [2:0] GO_NONE  = 3'd0;
  localparam logic [2:0] GO_UP    = 3'd1;
  localparam logic [2:0] GO_DOWN  = 3'd2;
  localparam logic [2:0] GO_LEFT  = 3'd3;
  localparam logic [2:0] GO_RIGHT = 3'd4;

  state_t           state_q;
  logic [IDX_W-1:0] board_q [N];
  logic [IDX_W-1:0] blank_q;
  logic [IDX_W-1:0] from_q;
  logic [IDX_W-1:0] to_q;
  logic             valid_q;
  logic             blocked_q;
  logic [CNT_W-1:0] count_q;

  logic [IDX_W-1:0] row;
  logic [IDX_W-1:0] col;
  logic [IDX_W-1:0] target_d;
  logic             legal_d;

  assign row = blank_q / IDX_W'(COLS);
  assign col = blank_q % IDX_W'(COLS);

  // The blank moves opposite to the tile: UP pulls the tile below into the blank.
  always_comb begin
    legal_d  = 1'b0;
    target_d = blank_q;
    case (go)
      GO_UP: begin
        legal_d  = (row < IDX_W'(ROWS - 1));
        target_d = blank_q + IDX_W'(COLS);
      end
      GO_DOWN: begin
        legal_d  = (row != '0);
        target_d = blank_q - IDX_W'(COLS);
      end
      GO_LEFT: begin
        legal_d  = (col < IDX_W'(COLS - 1));
        target_d = blank_q + IDX_W'(1);
      end
      GO_RIGHT: begin
        legal_d  = (col != '0);
        target_d = blank_q - IDX_W'(1);
      end
      default: begin
        legal_d  = 1'b0;
        target_d = blank_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      for (int i = 0; i < N; i++) board_q[i] <= IDX_W'((i + 1) % N);
      blank_q   <= IDX_W'(N - 1);
      from_q    <= IDX_W'(N - 1);
      to_q      <= IDX_W'(N - 1);
      valid_q   <= 1'b0;
      blocked_q <= 1'b0;
      count_q   <= '0;
    end else begin
      valid_q   <= 1'b0;
      blocked_q <= 1'b0;
      if (load) begin
        // Land in HOLD so a key still held during the restore is not acted on.
        state_q <= HOLD;
        for (int i = 0; i < N; i++) board_q[i] <= IDX_W'((i + 1) % N);
        blank_q <= IDX_W'(N - 1);
        from_q  <= IDX_W'(N - 1);
        to_q    <= IDX_W'(N - 1);
        count_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (go != GO_NONE) begin
              state_q <= HOLD;
              if (legal_d) begin
                board_q[target_d] <= '0;
                board_q[blank_q]  <= board_q[target_d];
                blank_q <= target_d;
                from_q  <= target_d;
                to_q    <= blank_q;
                valid_q <= 1'b1;
                if (count_q != {CNT_W{1'b1}}) count_q <= count_q + CNT_W'(1);
              end else begin
                blocked_q <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (go == GO_NONE) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    solved = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (board_q[i] != IDX_W'((i + 1) % N)) solved = 1'b0;
    end
  end

  assign rd_tile      = (int'(rd_addr) < N) ? board_q[rd_addr] : '0;
  assign blank_pos    = blank_q;
  assign move_valid   = valid_q;
  assign move_blocked = blocked_q;
  assign move_from    = from_q;
  assign move_to      = to_q;
  assign move_count   = count_q;

endmodule
